// File: rtl/mem_arbiter_rr_if.sv
// Request/grant and memory-strobe bundle between two clients,
// the round-robin arbiter and the asynchronous memory port.
interface mem_arbiter_rr_if #(
  parameter int AW = 8
);
  logic          req0;
  logic          req1;
  logic          rw0;
  logic          rw1;
  logic          burst0;
  logic          burst1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          own0;
  logic          own1;
  logic          done0;
  logic          done1;
  logic          oe;
  logic          we;
  logic [AW-1:0] mem_addr;
  logic          busy;

  modport master (
    output req0, req1, rw0, rw1,
    output burst0, burst1, addr0, addr1,
    input  gnt0, gnt1, own0, own1,
    input  done0, done1, oe, we,
    input  mem_addr, busy
  );

  modport slave (
    input  req0, req1, rw0, rw1,
    input  burst0, burst1, addr0, addr1,
    output gnt0, gnt1, own0, own1,
    output done0, done1, oe, we,
    output mem_addr, busy
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-client round-robin arbiter and access sequencer for the
// shared async-memory port: single read, 4-beat burst read, write.
module mem_arbiter_rr #(
  parameter int AW = 8
) (
  input logic             clk,
  input logic             reset,
  mem_arbiter_rr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          own_q, own_d;
  logic          burst_q, burst_d;
  logic [1:0]    beat_q, beat_d;
  logic [AW-1:0] addr_q, addr_d;

  logic sel;
  logic last;
  logic rd;
  logic wr;
  logic first;
  logic fin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      burst_q <= 1'b0;
      beat_q  <= 2'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

  // On contention ptr picks; otherwise the lone requester wins.
  assign sel  = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
  assign last = beat_q == (burst_q ? 2'd3 : 2'd0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          own_d   = sel;
          addr_d  = sel ? bus.addr1 : bus.addr0;
          burst_d = sel ? bus.burst1 : bus.burst0;
          beat_d  = 2'd0;
          if (sel ? bus.rw1 : bus.rw0)
            state_d = READ;
          else
            state_d = WRITE;
        end
      end
      READ: begin
        beat_d = beat_q + 2'd1;
        if (last) begin
          state_d = IDLE;
          ptr_d   = ~own_q;
        end
      end
      WRITE: begin
        state_d = IDLE;
        ptr_d   = ~own_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd    = state_q == READ;
  assign wr    = state_q == WRITE;
  assign first = wr | (rd & (beat_q == 2'd0));
  assign fin   = wr | (rd & last);

  assign bus.busy  = rd | wr;
  assign bus.oe    = rd;
  assign bus.we    = wr;
  assign bus.own0  = (rd | wr) & ~own_q;
  assign bus.own1  = (rd | wr) & own_q;
  assign bus.gnt0  = first & ~own_q;
  assign bus.gnt1  = first & own_q;
  assign bus.done0 = fin & ~own_q;
  assign bus.done1 = fin & own_q;

  // Burst beats wrap inside the aligned 4-word block.
  assign bus.mem_addr =
    rd ? {addr_q[AW-1:2], addr_q[1:0] + beat_q} :
    wr ? addr_q : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: reset, single/burst reads,
// contention, pending write during burst, reset mid-burst.
module tb_mem_arbiter_rr;

  localparam int AW = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_arbiter_rr_if #(.AW(AW)) bus ();

  mem_arbiter_rr #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g0 g1 o0 o1 d0 d1 oe we busy
  localparam logic [8:0] IDL = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] W0  = 9'b1_0_1_0_1_0_0_1_1;
  localparam logic [8:0] W1  = 9'b0_1_0_1_0_1_0_1_1;
  localparam logic [8:0] R1  = 9'b0_1_0_1_0_1_1_0_1;
  localparam logic [8:0] R0  = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] B0F = 9'b1_0_1_0_0_0_1_0_1;
  localparam logic [8:0] B0M = 9'b0_0_1_0_0_0_1_0_1;
  localparam logic [8:0] B0L = 9'b0_0_1_0_1_0_1_0_1;

  function automatic logic [8:0] outs();
    return {bus.gnt0, bus.gnt1, bus.own0, bus.own1,
            bus.done0, bus.done1, bus.oe, bus.we, bus.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [8:0] eo,
                     input logic [AW-1:0] ea);
    logic [8:0]    o;
    logic [AW-1:0] a;
    o = outs();
    a = bus.mem_addr;
    n_tests++;
    assert (o === eo && a === ea) else begin
      n_fail++;
      $error("FAIL %s: outs=%b addr=%h, expected outs=%b addr=%h",
             tag, o, a, eo, ea);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset      = 1'b0;
    bus.req0   = 1'b1;
    bus.req1   = 1'b1;
    bus.rw0    = 1'b0;
    bus.rw1    = 1'b0;
    bus.burst0 = 1'b0;
    bus.burst1 = 1'b0;
    bus.addr0  = 8'h01;
    bus.addr1  = 8'h02;

    // reset held with both requests high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", IDL, 8'h00);
    end
    reset = 1'b1;
    tick();
    chk("post_reset_gnt0", W0, 8'h01);
    bus.req0 = 1'b0;
    tick();
    chk("post_reset_idle", IDL, 8'h00);
    tick();
    chk("post_reset_gnt1", W1, 8'h02);
    bus.req1 = 1'b0;
    tick();
    chk("post_reset_idle2", IDL, 8'h00);

    // contention, single writes, ptr = 0
    bus.addr0 = 8'h10;
    bus.addr1 = 8'h20;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    tick(); chk("cont_g0_a", W0, 8'h10);
    tick(); chk("cont_idle_a", IDL, 8'h00);
    tick(); chk("cont_g1_a", W1, 8'h20);
    tick(); chk("cont_idle_b", IDL, 8'h00);
    tick(); chk("cont_g0_b", W0, 8'h10);
    tick(); chk("cont_idle_c", IDL, 8'h00);
    tick(); chk("cont_g1_b", W1, 8'h20);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick(); chk("cont_end", IDL, 8'h00);

    // single read, client 1
    bus.req1   = 1'b1;
    bus.rw1    = 1'b1;
    bus.burst1 = 1'b0;
    bus.addr1  = 8'h40;
    tick(); chk("rd1_single", R1, 8'h40);
    bus.req1 = 1'b0;
    tick(); chk("rd1_idle", IDL, 8'h00);

    // burst wrap, client 0, write from client 1 arrives mid-burst
    bus.req0   = 1'b1;
    bus.rw0    = 1'b1;
    bus.burst0 = 1'b1;
    bus.addr0  = 8'h16;
    tick(); chk("burst_b0", B0F, 8'h16);
    bus.req0 = 1'b0;
    tick(); chk("burst_b1", B0M, 8'h17);
    bus.req1  = 1'b1;
    bus.rw1   = 1'b0;
    bus.addr1 = 8'h33;
    tick(); chk("burst_b2", B0M, 8'h14);
    tick(); chk("burst_b3", B0L, 8'h15);
    tick(); chk("burst_gap", IDL, 8'h00);
    tick(); chk("pend_wr1", W1, 8'h33);
    bus.req1 = 1'b0;
    tick(); chk("pend_idle", IDL, 8'h00);

    // client 0 single read leaves ptr = 1
    bus.req0   = 1'b1;
    bus.burst0 = 1'b0;
    bus.addr0  = 8'h05;
    tick(); chk("rd0_single", R0, 8'h05);
    bus.req0 = 1'b0;
    tick(); chk("rd0_idle", IDL, 8'h00);

    // reset mid-burst on beat 2
    bus.req0   = 1'b1;
    bus.burst0 = 1'b1;
    bus.addr0  = 8'h08;
    tick(); chk("abort_b0", B0F, 8'h08);
    bus.req0 = 1'b0;
    tick(); chk("abort_b1", B0M, 8'h09);
    tick(); chk("abort_b2", B0M, 8'h0a);
    reset = 1'b0;
    tick(); chk("abort_reset", IDL, 8'h00);
    reset = 1'b1;
    tick(); chk("abort_no_done", IDL, 8'h00);

    // ptr must be back to 0: contention grants client 0
    bus.rw0   = 1'b0;
    bus.rw1   = 1'b0;
    bus.addr0 = 8'hA0;
    bus.addr1 = 8'hB0;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    tick(); chk("abort_ptr0", W0, 8'hA0);
    bus.req0 = 1'b0;
    tick(); chk("abort_ptr_idle", IDL, 8'h00);
    tick(); chk("abort_ptr_g1", W1, 8'hB0);
    bus.req1 = 1'b0;
    tick(); chk("final_idle", IDL, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Two-client round-robin arbiter and access sequencer for the shared asynchronous-memory port. It accepts single-read, 4-beat burst-read and single-write requests from two requesters and grants the port to one of them. For the granted transaction it drives the memory strobes (oe, we) and the beat address, and signals grant and completion back to the owner. It replaces direct requester control of the memory FSM: requesters no longer drive mem/rw/burst themselves.

## Interface
- AW, 8, memory address width (AW >= 2)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block
- req0, req1  in  1  request from client 0/1; held high until that client's gnt pulse
- rw0, rw1  in  1  1 = read, 0 = write; sampled with req
- burst0, burst1  in  1  1 = 4-beat burst (reads only; ignored for writes)
- addr0, addr1  in  AW  start address; sampled with req
- gnt0, gnt1  out  1  one-cycle pulse on the first access cycle of that client's transaction
- own0, own1  out  1  high for every access cycle of that client's transaction; at most one high
- done0, done1  out  1  one-cycle pulse on the last access cycle of that client's transaction
- oe  out  1  memory output enable; high during read beats
- we  out  1  memory write enable; high during the write cycle
- mem_addr  out  AW  memory address for the current beat; 0 when idle
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, READ, WRITE. A 2-bit beat counter `beat` and a last-beat index `nbeat` are used in READ (nbeat = 3 for a burst, 0 for a single read).
- IDLE: if neither req is high, stay in IDLE.
- IDLE, exactly one req high: select that client.
- IDLE, both req high: select the client with priority `ptr` (1-bit). On reset, ptr = 0.
- Selection, latched at the clock edge:
  - owner, rw, burst and addr of the selected client are latched.
  - beat is set to 0.
  - Next state is READ if rw=1, else WRITE.
- READ:
  - oe = 1.
  - mem_addr = {addr[AW-1:2], addr[1:0] + beat}. The low 2 bits wrap modulo 4, so the burst stays inside the aligned 4-word block. The upper bits never change.
  - beat increments each cycle.
  - On the cycle where beat == nbeat, the next state is IDLE.
- WRITE:
  - we = 1, mem_addr = addr, one cycle only.
  - The next state is IDLE.
- ptr update: on leaving READ/WRITE, ptr becomes the non-owner, so the last-served client gets the lowest priority.
- At least one IDLE cycle separates consecutive transactions.
- A req still high in that IDLE cycle is treated as a new request. Clients must drop req after their gnt pulse.
- oe and we are never high together. own0/own1 are mutually exclusive.
- Reset mid-transaction:
  - The next edge with reset=0 forces IDLE and ptr = 0.
  - All outputs drop to 0.
  - No done pulse is issued for the aborted transaction.
- All outputs are decoded from registered state only (Moore). No combinational path from req to any output.

## Timing
- Reset values: gnt0, gnt1, own0, own1, done0, done1, oe, we, busy = 0; mem_addr = 0; state = IDLE; ptr = 0.
- Request first seen high in IDLE at edge t: first access cycle is t+1. In that cycle gnt, own, busy and oe/we are all high together.
- Single read or write: one access cycle (t+1). gnt and done pulse together. Back in IDLE at t+2.
- Burst read: access cycles t+1 through t+4, with oe high throughout. gnt at t+1, done at t+4. Back in IDLE at t+5.
- Earliest next grant after returning to IDLE at edge u is the access cycle u+1.
- Throughput: a single access every 2 cycles; a burst every 5 cycles.

## Test plan
- Reset: hold reset=0 for 3 cycles with both reqs high -> every output is 0 and busy = 0; after release, client 0 is granted first.
- Single read, client 1: req1=1, rw1=1, burst1=0, addr1=8'h40 -> one cycle with oe=1, gnt1=done1=own1=1, mem_addr=8'h40; then idle.
- Burst wrap, client 0: addr0=8'h16, rw0=1, burst0=1 -> mem_addr sequence 8'h16, 8'h17, 8'h14, 8'h15, oe high for 4 cycles, gnt0 on beat 0, done0 on beat 3.
- Contention: req0 and req1 held continuously with single writes -> grants alternate 0, 1, 0, 1; we high 1 cycle in every 2; oe never high.
- Burst with write pending: client 0 bursts while req1 write arrives mid-burst -> the burst completes uninterrupted, one IDLE cycle follows, then gnt1 with we=1.
- Reset mid-burst: reset=0 on beat 2 -> the next cycle has oe=0 and busy=0, done0 never pulses, and ptr = 0.
